// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bus: imem port, hazard/redirect controls, IF/ID outputs
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        pc_fault;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    output imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, pc_fault, fetch_count
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_target, imem_instr,
    input  imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid, pc_fault, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, redirects, stall/flush, IF/ID register, PC fault
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;
  logic        misaligned;
  logic        out_of_range;

  always_comb begin
    pc_plus4     = pc_q + 32'd4;
    redirect     = bus.jump | bus.branch_taken;
    target       = bus.jump ? bus.jump_target : bus.branch_target;
    misaligned   = redirect && (target[1:0] != 2'b00);
    out_of_range = {1'b0, pc_q} >= PC_LIMIT;

    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;

    if (fault_q) begin
      // Frozen until reset: PC holds, IF/ID carries only bubbles.
      instr_d = 32'h0;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else begin
      if (redirect) begin
        pc_d = {target[31:2], 2'b00};
      end else if (!bus.stall) begin
        pc_d = pc_plus4;
      end

      // A redirect squashes the wrong-path word; an out-of-range fetch is discarded.
      if (out_of_range || bus.flush || redirect) begin
        instr_d = 32'h0;
        pc4_d   = 32'h0;
        valid_d = 1'b0;
      end else if (!bus.stall) begin
        instr_d = bus.imem_instr;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end

      if (misaligned || out_of_range) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc_plus4 = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.pc_fault       = fault_q;
  assign bus.fetch_count    = count_q;

endmodule
